// File: rtl/tf_fetch_sequencer.sv
// tf_fetch_sequencer
// Walks the horizontal twiddle ROM of the radix-16 NTT pipeline stage by
// stage. It issues one ROM read per enabled cycle and holds each factor index
// for GRP_LEN beats. The registered ROM word is then offered to the butterfly
// datapath.
//
// Handshake: tf_data/tf_last are valid while tf_valid=1 and are consumed on a
// cycle with tf_valid && tf_ready. While tf_valid=1 and tf_ready=0 the word,
// tf_last and the ROM address all hold, because no new read is issued.
// tf_valid never drops without a handshake except on abort or reset.
//
// Reset is asynchronous and active-high on the port named rst_n.
module tf_fetch_sequencer #(
  parameter int P_WIDTH    = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int SC_WIDTH   = 3,
  parameter int MAX_STAGES = 4,
  parameter int BEATS      = 64,
  parameter int GRP_LEN    = 4,
  parameter int GAP        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SC_WIDTH-1:0]   num_stages,
  input  logic [P_WIDTH-1:0]    rom_q,
  input  logic                  tf_ready,
  output logic                  rom_cen_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [SC_WIDTH-1:0]   stage_counter,
  output logic [P_WIDTH-1:0]    tf_data,
  output logic                  tf_valid,
  output logic                  tf_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [2:0]            dbg_state
);

  localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW  = $clog2(GRP_LEN);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [BW-1:0]       beat;
  logic [SC_WIDTH-1:0] stage;
  logic [SC_WIDTH-1:0] last_stage;
  logic [GCW-1:0]      gap_cnt;
  logic                issue;
  logic                beat_last;
  logic                stage_last;
  logic                cfg_ok;

  // Factor index for a beat is beat/GRP_LEN. The stride grows by 4x per stage
  // and wraps modulo the ROM depth.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [BW-1:0] b,
                                                    input logic [SC_WIDTH-1:0] s);
    logic [31:0] idx;
    idx = 32'(b) >> GW;
    idx = idx << (2 * s);
    return idx[ADDR_WIDTH-1:0];
  endfunction

  // Read issue: only in RUN, and only when the output slot is free or being drained.
  always_comb begin
    issue      = (state == S_RUN) && (!tf_valid || tf_ready);
    beat_last  = (beat == BW'(BEATS - 1));
    stage_last = (stage == last_stage);
    cfg_ok     = (32'(num_stages) >= 32'd1) && (32'(num_stages) <= 32'(MAX_STAGES));
  end

  assign rom_cen_n = !issue;
  assign tf_data   = rom_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Sequencer FSM, counters, address register and output valid/last registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= S_IDLE;
      beat          <= '0;
      stage         <= '0;
      last_stage    <= '0;
      gap_cnt       <= '0;
      rom_addr      <= '0;
      stage_counter <= '0;
      tf_valid      <= 1'b0;
      tf_last       <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Cancel: drop everything in flight and return to IDLE without done.
        state         <= S_IDLE;
        beat          <= '0;
        stage         <= '0;
        gap_cnt       <= '0;
        rom_addr      <= '0;
        stage_counter <= '0;
        tf_valid      <= 1'b0;
        tf_last       <= 1'b0;
      end else begin
        // The ROM word appears one cycle after the read, so valid and last
        // follow the issue by one register stage.
        if (issue) begin
          tf_valid <= 1'b1;
          tf_last  <= beat_last;
        end else if (tf_valid && tf_ready) begin
          tf_valid <= 1'b0;
          tf_last  <= 1'b0;
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state         <= S_RUN;
                last_stage    <= num_stages - 1'b1;
                beat          <= '0;
                stage         <= '0;
                gap_cnt       <= '0;
                rom_addr      <= '0;
                stage_counter <= '0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end

          S_RUN: begin
            if (issue) begin
              if (beat_last) begin
                beat <= '0;
                if (stage_last) begin
                  state <= S_DRAIN;
                end else begin
                  stage         <= stage + 1'b1;
                  stage_counter <= stage + 1'b1;
                  rom_addr      <= addr_of('0, stage + 1'b1);
                  if (GAP > 0) begin
                    state   <= S_GAP;
                    gap_cnt <= '0;
                  end
                end
              end else begin
                beat     <= beat + 1'b1;
                rom_addr <= addr_of(beat + 1'b1, stage);
              end
            end
          end

          S_GAP: begin
            // Exactly GAP dead cycles before the next stage starts issuing.
            if (gap_cnt == GCW'(GAP - 1)) begin
              state <= S_RUN;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end

          S_DRAIN: begin
            if (tf_valid && tf_ready) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end

          S_DONE: begin
            state         <= S_IDLE;
            beat          <= '0;
            stage         <= '0;
            rom_addr      <= '0;
            stage_counter <= '0;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
